// File: rtl/ctrl_chk_pkg.sv
// ctrl_chk_pkg: shared definitions for the UDLX control-signal window checker.
// Holds the opcode constants, the ctrl_sigs bit order, the expected-mask
// decoder and the pending-check slot record.
package ctrl_chk_pkg;

    // Default control vector width and the width of a stored expected mask.
    localparam int NUM_SIGS_DEF = 10;
    localparam int MASK_W       = NUM_SIGS_DEF;

    // Bit positions inside ctrl_sigs.
    localparam int B_REG_RD_EN1        = 0;
    localparam int B_REG_RD_EN2        = 1;
    localparam int B_REG_WR_EN         = 2;
    localparam int B_IMM_INST          = 3;
    localparam int B_MEM_DATA_RD_EN    = 4;
    localparam int B_MEM_DATA_WR_EN    = 5;
    localparam int B_WRITE_BACK_MUX_SEL = 6;
    localparam int B_BRANCH_INST       = 7;
    localparam int B_JUMP_INST         = 8;
    localparam int B_JUMP_USE_R        = 9;

    // UDLX opcodes, instruction[31:26].
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JPC   = 6'h02;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_BRFL  = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_JR    = 6'h12;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // One pending check: occupancy, edges since issue, opcode, expected mask.
    typedef struct packed {
        logic              valid;
        logic [3:0]        age;
        logic [5:0]        op;
        logic [MASK_W-1:0] mask;
    } chk_slot_t;

    // Control bits that must all assert for an instruction; 0 means untracked.
    function automatic logic [MASK_W-1:0] exp_mask(input logic [5:0] op,
                                                   input logic [5:0] funct);
        logic [MASK_W-1:0] m;
        m = '0;
        case (op)
            OP_LW: begin
                m[B_REG_RD_EN1]         = 1'b1;
                m[B_REG_WR_EN]          = 1'b1;
                m[B_IMM_INST]           = 1'b1;
                m[B_MEM_DATA_RD_EN]     = 1'b1;
                m[B_WRITE_BACK_MUX_SEL] = 1'b1;
            end
            OP_RTYPE: begin
                // funct 0 is the NOP encoding and is never checked.
                if (funct != 6'd0) begin
                    m[B_REG_RD_EN1] = 1'b1;
                    m[B_REG_RD_EN2] = 1'b1;
                    m[B_REG_WR_EN]  = 1'b1;
                end
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                m[B_REG_RD_EN1] = 1'b1;
                m[B_REG_WR_EN]  = 1'b1;
                m[B_IMM_INST]   = 1'b1;
            end
            OP_SW: begin
                m[B_REG_RD_EN1]     = 1'b1;
                m[B_REG_RD_EN2]     = 1'b1;
                m[B_IMM_INST]       = 1'b1;
                m[B_MEM_DATA_WR_EN] = 1'b1;
            end
            OP_BEQZ, OP_BNEZ, OP_BRFL: begin
                m[B_REG_RD_EN1]  = 1'b1;
                m[B_IMM_INST]    = 1'b1;
                m[B_BRANCH_INST] = 1'b1;
            end
            OP_JR: begin
                m[B_REG_RD_EN1] = 1'b1;
                m[B_JUMP_INST]  = 1'b1;
                m[B_JUMP_USE_R] = 1'b1;
            end
            OP_JPC: m[B_JUMP_INST] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ctrl_chk_slot.sv
// ctrl_chk_slot: one pending-check slot. Stores op/mask, ages once per edge
// and reports pass (match inside the window) or fail (no match by MAX_LAT).
// A slot that passes or fails frees itself on the same edge.
module ctrl_chk_slot
    import ctrl_chk_pkg::*;
#(
    parameter int NUM_SIGS = NUM_SIGS_DEF,
    parameter int MIN_LAT  = 1,
    parameter int MAX_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                alloc,
    input  logic [5:0]          alloc_op,
    input  logic [NUM_SIGS-1:0] alloc_mask,
    input  logic [NUM_SIGS-1:0] ctrl_sigs,
    output logic                occupied,
    output logic                pass_evt,
    output logic                fail_evt,
    output logic [5:0]          slot_op,
    output logic [NUM_SIGS-1:0] missing
);

    localparam logic [3:0] MIN_A = 4'(MIN_LAT);
    localparam logic [3:0] MAX_A = 4'(MAX_LAT);

    chk_slot_t           slot_q;
    logic [3:0]          age_nxt;
    logic [NUM_SIGS-1:0] mask_n;
    logic                hit;

    // Evaluate at the incremented age; matches before MIN_LAT are ignored.
    always_comb begin
        age_nxt  = slot_q.age + 4'd1;
        mask_n   = NUM_SIGS'(slot_q.mask);
        hit      = ((ctrl_sigs & mask_n) == mask_n);
        pass_evt = slot_q.valid && hit && (age_nxt >= MIN_A);
        fail_evt = slot_q.valid && !pass_evt && (age_nxt >= MAX_A);
        missing  = mask_n & ~ctrl_sigs;
    end

    assign occupied = slot_q.valid;
    assign slot_op  = slot_q.op;

    // Slot storage: clear wins, then allocation (only into a free slot), then retire/age.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (clear) begin
            slot_q <= '0;
        end else if (alloc) begin
            slot_q.valid <= 1'b1;
            slot_q.age   <= 4'd0;
            slot_q.op    <= alloc_op;
            slot_q.mask  <= MASK_W'(alloc_mask);
        end else if (pass_evt || fail_evt) begin
            slot_q <= '0;
        end else if (slot_q.valid) begin
            slot_q.age <= age_nxt;
        end
    end

endmodule

// File: rtl/ctrl_window_checker.sv
// ctrl_window_checker: checks that the control bits expected for each fetched
// instruction all assert within [MIN_LAT, MAX_LAT] edges of its issue edge.
// Optional feature macro: CHK_FIRST_ERR_EN (first-failure capture registers).
// All outputs are registered and reset to 0; clear acts as a synchronous reset.
module ctrl_window_checker
    import ctrl_chk_pkg::*;
#(
    parameter int NUM_SIGS  = NUM_SIGS_DEF,
    parameter int DEPTH     = 4,
    parameter int MIN_LAT   = 1,
    parameter int MAX_LAT   = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 instr_valid,
    input  logic [5:0]           instr_op,
    input  logic [5:0]           instr_funct,
    input  logic [NUM_SIGS-1:0]  ctrl_sigs,
    output logic                 violation,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] pass_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 first_err_valid,
    output logic [5:0]           first_err_op,
    output logic [NUM_SIGS-1:0]  first_err_missing,
    output logic                 busy
);

    localparam int EW = $clog2(DEPTH + 2);

    logic [NUM_SIGS-1:0] issue_mask;
    logic                tracked, issue_hit, issue_pass, issue_fail, need_slot;
    logic [DEPTH-1:0]    occ, s_pass, s_fail, alloc_vec;
    logic [5:0]          s_op      [DEPTH];
    logic [NUM_SIGS-1:0] s_missing [DEPTH];
    logic                any_free, drop, busy_nxt;
    logic [EW:0]         pass_n, fail_n;
    logic [5:0]          cap_op;
    logic [NUM_SIGS-1:0] cap_missing;

    // Saturating add of an event count to a counter.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [EW:0] b);
        logic [CNT_WIDTH+EW:0] s;
        s = {{(EW+1){1'b0}}, a} + {{CNT_WIDTH{1'b0}}, b};
        if (s[CNT_WIDTH+EW:CNT_WIDTH] != '0) return '1;
        return s[CNT_WIDTH-1:0];
    endfunction

    // Issue-edge decode: with MIN_LAT=0 a match resolves without a slot; with
    // MAX_LAT=0 a miss also resolves immediately as a failure.
    always_comb begin
        issue_mask = NUM_SIGS'(exp_mask(instr_op, instr_funct));
        tracked    = instr_valid && (issue_mask != '0);
        issue_hit  = ((ctrl_sigs & issue_mask) == issue_mask);
        issue_pass = tracked && (MIN_LAT == 0) && issue_hit;
        issue_fail = tracked && (MAX_LAT == 0) && !issue_hit;
        need_slot  = tracked && !issue_pass && !issue_fail;
    end

    // Lowest-index slot that was free before this edge; slots retiring now are not reused.
    always_comb begin
        alloc_vec = '0;
        any_free  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!occ[i] && !any_free) begin
                alloc_vec[i] = need_slot;
                any_free     = 1'b1;
            end
        end
        drop     = need_slot && !any_free;
        busy_nxt = |((occ & ~(s_pass | s_fail)) | alloc_vec);
    end

    // Event totals for this edge and the lowest-index failing slot's details.
    always_comb begin
        pass_n      = (EW+1)'(issue_pass);
        fail_n      = (EW+1)'(issue_fail);
        cap_op      = instr_op;
        cap_missing = issue_mask & ~ctrl_sigs;
        for (int i = 0; i < DEPTH; i++) begin
            pass_n = pass_n + (EW+1)'(s_pass[i]);
            fail_n = fail_n + (EW+1)'(s_fail[i]);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s_fail[i]) begin
                cap_op      = s_op[i];
                cap_missing = s_missing[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        ctrl_chk_slot #(
            .NUM_SIGS (NUM_SIGS),
            .MIN_LAT  (MIN_LAT),
            .MAX_LAT  (MAX_LAT)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear),
            .alloc      (alloc_vec[g]),
            .alloc_op   (instr_op),
            .alloc_mask (issue_mask),
            .ctrl_sigs  (ctrl_sigs),
            .occupied   (occ[g]),
            .pass_evt   (s_pass[g]),
            .fail_evt   (s_fail[g]),
            .slot_op    (s_op[g]),
            .missing    (s_missing[g])
        );
    end

    // Counters, violation pulse, sticky flag and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            violation  <= 1'b0;
            err_sticky <= 1'b0;
            pass_count <= '0;
            err_count  <= '0;
            drop_count <= '0;
            busy       <= 1'b0;
        end else if (clear) begin
            violation  <= 1'b0;
            err_sticky <= 1'b0;
            pass_count <= '0;
            err_count  <= '0;
            drop_count <= '0;
            busy       <= 1'b0;
        end else begin
            violation  <= (fail_n != '0);
            err_sticky <= err_sticky | (fail_n != '0);
            pass_count <= sat_add(pass_count, pass_n);
            err_count  <= sat_add(err_count, fail_n);
            drop_count <= sat_add(drop_count, (EW+1)'(drop));
            busy       <= busy_nxt;
        end
    end

`ifdef CHK_FIRST_ERR_EN
    // Capture the first failure only; later failures leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_err_valid   <= 1'b0;
            first_err_op      <= '0;
            first_err_missing <= '0;
        end else if (clear) begin
            first_err_valid   <= 1'b0;
            first_err_op      <= '0;
            first_err_missing <= '0;
        end else if (!first_err_valid && (fail_n != '0)) begin
            first_err_valid   <= 1'b1;
            first_err_op      <= cap_op;
            first_err_missing <= cap_missing;
        end
    end
`else
    logic unused_cap;
    assign unused_cap        = ^{cap_op, cap_missing};
    assign first_err_valid   = 1'b0;
    assign first_err_op      = '0;
    assign first_err_missing = '0;
`endif

endmodule
